uc_jogo_velha: RTL and testbench
================================

Name: uc_jogo_velha

Overview:
- Control unit (FSM) that sequences the ultimate tic-tac-toe datapath inside circuito_jogo.
- Decides when the datapath latches the macro choice and the micro choice, writes the board and switches player.
- Handles the redirect to free macro choice when the target macro board is already won.
- Drives the jogar_macro/jogar_micro/pronto indications and provides the db_estado debug code.

Parameters:
- none (state encoding is fixed in the package)

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-low: state is cleared on a rising clock edge while reset=0
- iniciar  in  1  start or restart request, level
- tem_jogada  in  1  datapath: at least one of botoes[8:0] is pressed (level, already synchronised)
- macro_vencido  in  1  datapath: the currently selected macro board is already won or full
- celula_ocupada  in  1  datapath: the selected micro cell is already occupied
- fim_jogo  in  1  datapath: the global board is won or drawn (valid one cycle after escreve)
- zera  out  1  clear all datapath registers and memories
- registra_macro  out  1  latch the button index as the macro index
- registra_micro  out  1  latch the button index as the micro index
- escreve  out  1  write the current player into (macro, micro) and update the macro result
- troca_jogador  out  1  toggle the current player
- proximo_macro  out  1  copy the micro index into the macro index
- jogar_macro  out  1  waiting for a macro choice
- jogar_micro  out  1  waiting for a micro choice
- pronto  out  1  game finished
- db_estado  out  4  current state code

Behaviour:
- Moore FSM: every output is decoded from the state register only. Each strobe is high for exactly one cycle, the cycle in which its state is occupied.
- Reset (reset=0 at a clock edge, at any time, including mid-game):
  - state <= INICIAL (0x0), destino <= 0.
  - All outputs 0; db_estado=0x0.
- destino: 1-bit register. 0 means return to ESPERA_MACRO, 1 means return to ESPERA_MICRO. It is written only in the VER_* states.
- States and transitions:
  - INICIAL (0x0): if iniciar -> PREPARA.
  - PREPARA (0x1): zera=1 -> ESPERA_MACRO.
  - ESPERA_MACRO (0x2): jogar_macro=1. If tem_jogada -> REG_MACRO.
  - REG_MACRO (0x3): registra_macro=1 -> VER_MACRO.
  - VER_MACRO (0x4): destino <= macro_vencido ? 0 : 1 -> SOLTA.
  - SOLTA (0xB): wait for button release. If !tem_jogada -> (destino ? ESPERA_MICRO : ESPERA_MACRO); else stay.
  - ESPERA_MICRO (0x5): jogar_micro=1. If tem_jogada -> REG_MICRO.
  - REG_MICRO (0x6): registra_micro=1 -> VER_CELULA.
  - VER_CELULA (0x7): if celula_ocupada, destino <= 1 -> SOLTA (move rejected); else -> ESCREVE.
  - ESCREVE (0x8): escreve=1 -> VER_FIM.
  - VER_FIM (0x9): if fim_jogo -> FIM; else -> TROCA.
  - TROCA (0xA): troca_jogador=1 and proximo_macro=1 -> VER_PROX.
  - VER_PROX (0xC): destino <= macro_vencido ? 0 : 1 -> SOLTA (the winning macro of the next play is free choice).
  - FIM (0xF): pronto=1. If iniciar -> PREPARA.
- Held buttons: a button held for many cycles produces exactly one registration. SOLTA blocks until release.
- iniciar: ignored in every state other than INICIAL and FIM.
- Simultaneous inputs:
  - tem_jogada together with iniciar in INICIAL: iniciar wins; tem_jogada is irrelevant there.
  - In ESPERA_* states, only tem_jogada is evaluated.
- Latency from button press to escreve: press seen in ESPERA_MICRO at cycle n -> REG_MICRO n+1 -> VER_CELULA n+2 -> escreve at n+3.
- Unused state codes (0xD, 0xE) -> INICIAL on the next edge.

Decomposition:
- Package jogo_velha_pkg:
  - state encoding constants (4-bit, values listed above)
  - constants DESTINO_MACRO=0 and DESTINO_MICRO=1
- Single module, no sub-module. The next-state logic, state register, destino register and output decode are small enough to live together.

Test Plan:
- Reset with reset=0 for one cycle -> db_estado=0x0 and all outputs 0. iniciar pulse -> zera high for exactly 1 cycle, then jogar_macro=1, db_estado=0x2.
- Macro press held 20 cycles, macro_vencido=0 -> registra_macro high for 1 cycle, db_estado 0x3, 0x4, then 0xB for the rest of the press. Release -> jogar_micro=1, 0x5.
- Micro press, celula_ocupada=0, fim_jogo=0:
  - escreve at press+3 cycles, then troca_jogador and proximo_macro together for 1 cycle.
  - With macro_vencido=0 after proximo_macro, release -> jogar_micro=1.
- Same as the previous case but macro_vencido=1 after proximo_macro -> release -> jogar_macro=1 (redirect to free choice). The next press 2 -> registra_macro.
- Micro press with celula_ocupada=1 -> no escreve and no troca_jogador; after release, back to 0x5.
- Micro press with fim_jogo=1 in VER_FIM -> db_estado=0xF and pronto=1. tem_jogada is ignored; iniciar -> zera.
- reset=0 asserted while in ESPERA_MICRO -> next edge db_estado=0x0, destino=0, jogar_micro=0.

Source files
------------

// File: rtl/jogo_velha_pkg.sv
// Shared encodings for the ultimate tic-tac-toe control unit: state codes,
// return-destination constants and the Moore output bundle.
package jogo_velha_pkg;

  typedef enum logic [3:0] {
    INICIAL      = 4'h0,
    PREPARA      = 4'h1,
    ESPERA_MACRO = 4'h2,
    REG_MACRO    = 4'h3,
    VER_MACRO    = 4'h4,
    ESPERA_MICRO = 4'h5,
    REG_MICRO    = 4'h6,
    VER_CELULA   = 4'h7,
    ESCREVE      = 4'h8,
    VER_FIM      = 4'h9,
    TROCA        = 4'hA,
    SOLTA        = 4'hB,
    VER_PROX     = 4'hC,
    FIM          = 4'hF
  } estado_t;

  localparam logic DESTINO_MACRO = 1'b0;
  localparam logic DESTINO_MICRO = 1'b1;

  typedef struct packed {
    logic zera;
    logic registra_macro;
    logic registra_micro;
    logic escreve;
    logic troca_jogador;
    logic proximo_macro;
    logic jogar_macro;
    logic jogar_micro;
    logic pronto;
  } saidas_t;

  function automatic saidas_t decodifica(input estado_t e);
    saidas_t o;
    o = '0;
    case (e)
      PREPARA:      o.zera = 1'b1;
      ESPERA_MACRO: o.jogar_macro = 1'b1;
      REG_MACRO:    o.registra_macro = 1'b1;
      ESPERA_MICRO: o.jogar_micro = 1'b1;
      REG_MICRO:    o.registra_micro = 1'b1;
      ESCREVE:      o.escreve = 1'b1;
      TROCA: begin
        o.troca_jogador = 1'b1;
        o.proximo_macro = 1'b1;
      end
      FIM:          o.pronto = 1'b1;
      default:      o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/uc_jogo_velha.sv
// Control FSM sequencing macro/micro selection, board write and player swap.
// Outputs are registered from the next state, so they track the state register exactly.
module uc_jogo_velha
  import jogo_velha_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       tem_jogada,
  input  logic       macro_vencido,
  input  logic       celula_ocupada,
  input  logic       fim_jogo,
  output logic       zera,
  output logic       registra_macro,
  output logic       registra_micro,
  output logic       escreve,
  output logic       troca_jogador,
  output logic       proximo_macro,
  output logic       jogar_macro,
  output logic       jogar_micro,
  output logic       pronto,
  output logic [3:0] db_estado
);

  estado_t estado, prox;
  logic    destino, destino_prox;
  saidas_t s;

  always_comb begin
    prox         = estado;
    destino_prox = destino;
    case (estado)
      INICIAL:      if (iniciar) prox = PREPARA;
      PREPARA:      prox = ESPERA_MACRO;
      ESPERA_MACRO: if (tem_jogada) prox = REG_MACRO;
      REG_MACRO:    prox = VER_MACRO;
      VER_MACRO: begin
        destino_prox = macro_vencido ? DESTINO_MACRO : DESTINO_MICRO;
        prox         = SOLTA;
      end
      // Held buttons park here so one press yields a single registration.
      SOLTA:        if (!tem_jogada) prox = destino ? ESPERA_MICRO : ESPERA_MACRO;
      ESPERA_MICRO: if (tem_jogada) prox = REG_MICRO;
      REG_MICRO:    prox = VER_CELULA;
      VER_CELULA:
        if (celula_ocupada) begin
          destino_prox = DESTINO_MICRO;
          prox         = SOLTA;
        end else begin
          prox = ESCREVE;
        end
      ESCREVE:      prox = VER_FIM;
      VER_FIM:      prox = fim_jogo ? FIM : TROCA;
      TROCA:        prox = VER_PROX;
      VER_PROX: begin
        destino_prox = macro_vencido ? DESTINO_MACRO : DESTINO_MICRO;
        prox         = SOLTA;
      end
      FIM:          if (iniciar) prox = PREPARA;
      default:      prox = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado  <= INICIAL;
      destino <= DESTINO_MACRO;
      s       <= '0;
    end else begin
      estado  <= prox;
      destino <= destino_prox;
      s       <= decodifica(prox);
    end
  end

  assign zera           = s.zera;
  assign registra_macro = s.registra_macro;
  assign registra_micro = s.registra_micro;
  assign escreve        = s.escreve;
  assign troca_jogador  = s.troca_jogador;
  assign proximo_macro  = s.proximo_macro;
  assign jogar_macro    = s.jogar_macro;
  assign jogar_micro    = s.jogar_micro;
  assign pronto         = s.pronto;
  assign db_estado      = estado;

endmodule

// File: tb/tb_uc_jogo_velha.sv
// Bench for uc_jogo_velha: directed vector table, hand sequences and a random
// walk, all checked against a game-level reference model.
module tb_uc_jogo_velha;

  logic clock = 1'b0;
  logic reset, iniciar, tem_jogada, macro_vencido, celula_ocupada, fim_jogo;
  logic zera, registra_macro, registra_micro, escreve, troca_jogador, proximo_macro;
  logic jogar_macro, jogar_micro, pronto;
  logic [3:0] db_estado;

  always #5 clock = ~clock;

  uc_jogo_velha dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .tem_jogada(tem_jogada),
    .macro_vencido(macro_vencido), .celula_ocupada(celula_ocupada), .fim_jogo(fim_jogo),
    .zera(zera), .registra_macro(registra_macro), .registra_micro(registra_micro),
    .escreve(escreve), .troca_jogador(troca_jogador), .proximo_macro(proximo_macro),
    .jogar_macro(jogar_macro), .jogar_micro(jogar_micro), .pronto(pronto),
    .db_estado(db_estado)
  );

  typedef struct {
    logic r, i, t, mv, co, f;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase of play plus where a released button sends us.
  int m_st = 0;
  bit m_back_micro = 0;

  function automatic void model(input bit r, i, t, mv, co, f);
    if (!r) begin
      m_st = 0; m_back_micro = 0;
      return;
    end
    case (m_st)
      0:  m_st = i ? 1 : 0;
      1:  m_st = 2;
      2:  m_st = t ? 3 : 2;
      3:  m_st = 4;
      4:  begin m_back_micro = !mv; m_st = 11; end
      11: m_st = t ? 11 : (m_back_micro ? 5 : 2);
      5:  m_st = t ? 6 : 5;
      6:  m_st = 7;
      7:  if (co) begin m_back_micro = 1; m_st = 11; end else m_st = 8;
      8:  m_st = 9;
      9:  m_st = f ? 15 : 10;
      10: m_st = 12;
      12: begin m_back_micro = !mv; m_st = 11; end
      15: m_st = i ? 1 : 15;
      default: m_st = 0;
    endcase
  endfunction

  // Expected indications per displayed code:
  // {zera, reg_macro, reg_micro, escreve, troca, prox, jogar_macro, jogar_micro, pronto}
  function automatic logic [8:0] outs_for(input int c);
    case (c)
      1:  return 9'h100;
      2:  return 9'h004;
      3:  return 9'h080;
      5:  return 9'h002;
      6:  return 9'h040;
      8:  return 9'h020;
      10: return 9'h018;
      15: return 9'h001;
      default: return 9'h000;
    endcase
  endfunction

  function automatic logic [8:0] dut_outs();
    return {zera, registra_macro, registra_micro, escreve, troca_jogador, proximo_macro,
            jogar_macro, jogar_micro, pronto};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare after the edge.
  task automatic step(input bit r, i, t, mv, co, f);
    logic [3:0] me;
    reset = r; iniciar = i; tem_jogada = t; macro_vencido = mv;
    celula_ocupada = co; fim_jogo = f;
    model(r, i, t, mv, co, f);
    @(posedge clock); #1;
    me = 4'(m_st);
    check("model", {db_estado, dut_outs()}, {me, outs_for(m_st)});
  endtask

  task automatic add(input logic r, i, t, mv, co, f, input logic [3:0] e);
    vec_t v;
    v.r = r; v.i = i; v.t = t; v.mv = mv; v.co = co; v.f = f; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    int pulses;
    logic [3:0] cur;
    reset = 1'b0; iniciar = 0; tem_jogada = 0; macro_vencido = 0;
    celula_ocupada = 0; fim_jogo = 0;
    #1;

    //  r  i  t mv co  f  state after edge
    add(0, 0, 0, 0, 0, 0, 4'h0);  // reset
    add(1, 0, 0, 0, 0, 0, 4'h0);
    add(1, 1, 0, 0, 0, 0, 4'h1);  // zera
    add(1, 0, 0, 0, 0, 0, 4'h2);
    add(1, 0, 1, 0, 0, 0, 4'h3);  // macro press
    add(1, 0, 1, 0, 0, 0, 4'h4);
    add(1, 0, 1, 0, 0, 0, 4'hB);
    add(1, 0, 1, 0, 0, 0, 4'hB);
    add(1, 0, 0, 0, 0, 0, 4'h5);
    add(1, 0, 1, 0, 0, 0, 4'h6);  // micro press, free cell
    add(1, 0, 1, 0, 0, 0, 4'h7);
    add(1, 0, 1, 0, 0, 0, 4'h8);
    add(1, 0, 1, 0, 0, 0, 4'h9);
    add(1, 0, 1, 0, 0, 0, 4'hA);
    add(1, 0, 1, 0, 0, 0, 4'hC);
    add(1, 0, 1, 0, 0, 0, 4'hB);  // next macro still open
    add(1, 0, 0, 0, 0, 0, 4'h5);
    add(1, 0, 1, 0, 0, 0, 4'h6);
    add(1, 0, 1, 0, 0, 0, 4'h7);
    add(1, 0, 1, 0, 0, 0, 4'h8);
    add(1, 0, 1, 0, 0, 0, 4'h9);
    add(1, 0, 1, 0, 0, 0, 4'hA);
    add(1, 0, 1, 0, 0, 0, 4'hC);
    add(1, 0, 1, 1, 0, 0, 4'hB);  // next macro already won
    add(1, 0, 0, 0, 0, 0, 4'h2);  // free choice
    add(1, 0, 1, 0, 0, 0, 4'h3);
    add(1, 0, 1, 0, 0, 0, 4'h4);
    add(1, 0, 1, 0, 0, 0, 4'hB);
    add(1, 0, 0, 0, 0, 0, 4'h5);
    add(1, 0, 1, 0, 0, 0, 4'h6);  // occupied cell
    add(1, 0, 1, 0, 0, 0, 4'h7);
    add(1, 0, 1, 0, 1, 0, 4'hB);
    add(1, 0, 0, 0, 0, 0, 4'h5);
    add(1, 0, 1, 0, 0, 0, 4'h6);  // winning move
    add(1, 0, 1, 0, 0, 0, 4'h7);
    add(1, 0, 1, 0, 0, 0, 4'h8);
    add(1, 0, 1, 0, 0, 1, 4'h9);
    add(1, 0, 1, 0, 0, 1, 4'hF);
    add(1, 0, 1, 0, 0, 0, 4'hF);
    add(1, 1, 0, 0, 0, 0, 4'h1);  // restart
    add(1, 0, 0, 0, 0, 0, 4'h2);
    add(1, 0, 1, 0, 0, 0, 4'h3);
    add(1, 0, 1, 0, 0, 0, 4'h4);
    add(1, 0, 1, 0, 0, 0, 4'hB);
    add(1, 0, 0, 0, 0, 0, 4'h5);
    add(0, 0, 0, 0, 0, 0, 4'h0);  // reset mid-game
    add(1, 0, 1, 0, 0, 0, 4'h0);  // button ignored in INICIAL
    add(1, 1, 1, 0, 0, 0, 4'h1);  // iniciar wins over button
    add(1, 0, 0, 0, 0, 0, 4'h2);

    foreach (vecs[k]) begin
      step(vecs[k].r, vecs[k].i, vecs[k].t, vecs[k].mv, vecs[k].co, vecs[k].f);
      check($sformatf("vec%0d", k), {9'h0, db_estado}, {9'h0, vecs[k].exp});
    end

    // Held macro press: one registration over 20 cycles, then park in SOLTA.
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      step(1, 0, 1, 0, 0, 0);
      pulses += int'(registra_macro);
    end
    check("held_pulses", 13'(pulses), 13'd1);
    check("held_state", {9'h0, db_estado}, 13'hB);
    step(1, 0, 0, 0, 0, 0);
    check("release_micro", {9'h0, db_estado, jogar_micro}, {9'h0, 4'h5, 1'b1});

    // FIM ignores presses until iniciar.
    step(1, 0, 1, 0, 0, 0); step(1, 0, 1, 0, 0, 0); step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0); step(1, 0, 0, 0, 0, 1);
    for (int c = 0; c < 5; c++) step(1, 0, c[0], 0, 0, 0);
    check("fim_hold", {11'h0, pronto, db_estado == 4'hF}, 13'h3);
    step(1, 1, 0, 0, 0, 0);
    check("restart_zera", {12'h0, zera}, 13'h1);

    // Random walk against the model.
    cur = 0;
    begin
      bit t = 0;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 5) == 0) t = !t;
        step(($urandom_range(0, 149) != 0), ($urandom_range(0, 19) == 0), t,
             $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000");
    $fatal(1);
  end

endmodule
